router_out_reader: RTL
======================

Name: router_out_reader

Overview:
- Destination-side read controller for one output port of the 1x3 router; one instance per port.
- Watches the port's vld_out and soft_reset from the synchronizer and drives read_enb to drain the port FIFO one packet at a time.
- Reassembles the packet as a framed byte stream (header / payload / parity), checks parity, and reports completion or abort.
- Must start reading within the synchronizer's 30-cycle window, otherwise the FIFO is soft-reset underneath it.

Parameters:
- DATA_W, 8, FIFO byte width.
- START_DELAY, 2, cycles to wait after vld_out rises before the header read; legal range 0..27.
- PORT_ID, 0, port index 0..2; used only by the optional feature.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- vld_out  in  1  port FIFO non-empty.
- soft_reset  in  1  timeout flush of this port's FIFO.
- data_out  in  DATA_W  FIFO read data, valid one cycle after read_enb was sampled high.
- pkt_ready  in  1  downstream throttle.
- read_enb  out  1  FIFO read strobe.
- pkt_data  out  DATA_W  forwarded byte.
- pkt_valid  out  1  pkt_data valid.
- pkt_sop  out  1  header beat.
- pkt_eop  out  1  parity beat.
- pkt_done  out  1  one-cycle pulse, packet completed.
- parity_err  out  1  one-cycle pulse with pkt_done on mismatch.
- abort  out  1  one-cycle pulse when a packet is dropped by soft_reset.
- busy  out  1  state != IDLE.
- pkt_count  out  8  good-packet count, wraps 255 -> 0.

Behaviour:
- Reset: resetn low at a clock edge clears all state. All outputs are 0; state IDLE; counters and parity accumulator are 0. Reset mid-packet discards the packet with no abort pulse.
- States:
  - IDLE: vld_out=1 goes to DELAY, or directly to RD_HDR if START_DELAY=0.
  - DELAY: counts START_DELAY cycles, then goes to RD_HDR.
  - RD_HDR: goes to LATCH on a fire.
  - LATCH: no read. Captures len=header[7:2] from data_out; len=0 goes to RD_PAR, else RD_PLD.
  - RD_PLD: issues exactly len fires, then goes to RD_PAR.
  - RD_PAR: goes to CHECK on a fire.
  - CHECK: one cycle, then IDLE.
- fire = read_enb = (state in RD_HDR/RD_PLD/RD_PAR) & vld_out & pkt_ready & ~soft_reset. Combinational, so a FIFO empty mid-packet or pkt_ready=0 stalls without loss.
- Every fire at cycle t produces exactly one beat at t+1: pkt_valid=1, pkt_data=data_out. pkt_sop is set on the header beat and pkt_eop on the parity beat. The beat is not held and does not wait for pkt_ready; pkt_ready only gates the next read.
- Parity: running XOR of header and all payload bytes, cleared in IDLE. In CHECK, the parity byte on data_out is compared against the accumulator. At the next cycle:
  - pkt_done=1.
  - parity_err = mismatch.
  - pkt_count increments only if there is no error.
  - Next packet's DELAY may begin that same cycle if vld_out=1.
- soft_reset=1 in any non-IDLE state:
  - read_enb forced 0 the same cycle.
  - Next cycle: state IDLE, abort=1, and any beat due that cycle is suppressed (pkt_valid=0).
  - soft_reset in IDLE has no effect.
- Simultaneous soft_reset and CHECK: abort takes priority; no pkt_done, no count.
- pkt_count wraps modulo 256.

Optional Feature:
- Macro READER_ADDR_CHECK_EN.
- Defined: adds output addr_err (1 bit). In LATCH, header[1:0] != PORT_ID sets a sticky flag. At completion, addr_err pulses with pkt_done and the packet is not counted. The stream is still forwarded unchanged.
- Undefined: no addr_err port; header[1:0] is ignored.

Decomposition:
- Shared package router_pkg holds:
  - the state enum (IDLE, DELAY, RD_HDR, LATCH, RD_PLD, RD_PAR, CHECK);
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0);
  - the TIMEOUT=30 constant;
  - DATA_W.
- One natural sub-module: router_parity_acc (clear/accumulate XOR register plus compare).

Test Plan:
- Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 8'h0C^11^22^33, START_DELAY=2, pkt_ready=1 -> header read 2 cycles after vld_out rises; 5 beats with sop on beat 1, eop on beat 5; pkt_done=1, parity_err=0, pkt_count=1.
- Same packet with parity byte ^8'h01 -> pkt_done=1, parity_err=1, pkt_count unchanged.
- Header 8'h01 (len 0), parity 8'h01 -> exactly 2 beats, sop then eop; LATCH goes straight to RD_PAR; pkt_count increments.
- pkt_ready low for 4 cycles mid-payload, vld_out dropping for 3 cycles mid-payload -> read_enb=0 during both stalls; no duplicated or dropped bytes; parity passes.
- soft_reset pulse while in RD_PLD after 2 of 5 payload bytes -> read_enb=0 same cycle; abort=1 next cycle; busy=0; no pkt_done; pkt_count unchanged; next packet is read correctly.
- 256 good packets back-to-back -> pkt_count wraps to 0. With READER_ADDR_CHECK_EN and PORT_ID=1, header addr 2 -> addr_err=1 with pkt_done; not counted.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port reader.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  localparam int TIMEOUT  = 30;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    RD_HDR,
    LATCH,
    RD_PLD,
    RD_PAR,
    CHECK
  } state_t;

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR over header and payload bytes, compared against the received parity byte.
module router_parity_acc #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clr,
  input  logic          acc_en,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] cmp_byte,
  output logic          mismatch
);

  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign mismatch = (cmp_byte != acc_q);

endmodule

// File: rtl/router_out_reader.sv
// Drains one router output FIFO a packet at a time and forwards it as a framed byte stream.
// Optional header address check enabled by defining READER_ADDR_CHECK_EN.
module router_out_reader
  import router_pkg::*;
#(
  parameter int DATA_W      = router_pkg::DATA_W,
  parameter int START_DELAY = 2,
  parameter int PORT_ID     = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld_out,
  input  logic              soft_reset,
  input  logic [DATA_W-1:0] data_out,
  input  logic              pkt_ready,
  output logic              read_enb,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              abort,
  output logic              busy,
  output logic [7:0]        pkt_count
`ifdef READER_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [4:0] DLY_LAST = 5'(START_DELAY - 1);

  state_t           state_q, state_d;
  logic [4:0]       dly_q, dly_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;
  logic             abort_q, abort_d;
  logic [7:0]       count_q, count_d;
  logic             fire;
  logic             mismatch;
  logic             addr_ok;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_len = data_out[LEN_MSB:LEN_LSB];
  assign fire = ((state_q == RD_HDR) || (state_q == RD_PLD) || (state_q == RD_PAR))
                && vld_out && pkt_ready && !soft_reset;

`ifdef READER_ADDR_CHECK_EN
  logic addr_bad_q, addr_bad_d;
  logic aerr_q, aerr_d;
  assign addr_ok = !addr_bad_q;
`else
  logic unused_port_id;
  assign unused_port_id = ^PORT_ID;
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rem_d   = rem_q;
    valid_d = fire;
    sop_d   = fire && (state_q == RD_HDR);
    eop_d   = fire && (state_q == RD_PAR);
    done_d  = 1'b0;
    perr_d  = 1'b0;
    abort_d = 1'b0;
    count_d = count_q;
`ifdef READER_ADDR_CHECK_EN
    addr_bad_d = addr_bad_q;
    aerr_d     = 1'b0;
`endif
    // A flush wins over everything, including a packet finishing in CHECK.
    if (soft_reset && (state_q != IDLE)) begin
      state_d = IDLE;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef READER_ADDR_CHECK_EN
          addr_bad_d = 1'b0;
`endif
          if (vld_out) begin
            if (START_DELAY == 0) begin
              state_d = RD_HDR;
            end else begin
              state_d = DELAY;
              dly_d   = '0;
            end
          end
        end
        DELAY: begin
          if (dly_q == DLY_LAST) begin
            state_d = RD_HDR;
          end else begin
            dly_d = dly_q + 5'd1;
          end
        end
        RD_HDR: begin
          if (fire) state_d = LATCH;
        end
        LATCH: begin
          rem_d   = hdr_len;
          state_d = (hdr_len == '0) ? RD_PAR : RD_PLD;
`ifdef READER_ADDR_CHECK_EN
          if (data_out[ADDR_MSB:ADDR_LSB] != 2'(PORT_ID)) addr_bad_d = 1'b1;
`endif
        end
        RD_PLD: begin
          if (fire) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = RD_PAR;
          end
        end
        RD_PAR: begin
          if (fire) state_d = CHECK;
        end
        CHECK: begin
          state_d = IDLE;
          done_d  = 1'b1;
          perr_d  = mismatch;
`ifdef READER_ADDR_CHECK_EN
          aerr_d  = addr_bad_q;
`endif
          if (!mismatch && addr_ok) count_d = count_q + 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      dly_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
`ifdef READER_ADDR_CHECK_EN
      addr_bad_q <= 1'b0;
      aerr_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
      count_q <= count_d;
`ifdef READER_ADDR_CHECK_EN
      addr_bad_q <= addr_bad_d;
      aerr_q     <= aerr_d;
`endif
    end
  end

  // The FIFO presents read data one cycle after the strobe, so the beat is data_out itself.
  router_parity_acc #(.DW(DATA_W)) u_parity (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (state_q == IDLE),
    .acc_en   (valid_q && !eop_q),
    .din      (data_out),
    .cmp_byte (data_out),
    .mismatch (mismatch)
  );

  assign read_enb   = fire;
  assign pkt_valid  = valid_q;
  assign pkt_data   = valid_q ? data_out : '0;
  assign pkt_sop    = sop_q;
  assign pkt_eop    = eop_q;
  assign pkt_done   = done_q;
  assign parity_err = perr_q;
  assign abort      = abort_q;
  assign busy       = (state_q != IDLE);
  assign pkt_count  = count_q;
`ifdef READER_ADDR_CHECK_EN
  assign addr_err   = aerr_q;
`endif

endmodule
